// File: rtl/logic_test_seq.sv
// Self-test sequencer for the logic_test gate block: walks {a,b} through 00..11,
// checks AND/OR/NOT/XOR on the last dwell cycle of each vector, and reports the results.
module logic_test_seq #(
    parameter int unsigned DWELL        = 10,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic       LS_i_clk,
    input  logic       LS_i_rst,
    input  logic       LS_i_start,
    output logic       LS_o_a,
    output logic       LS_o_b,
    input  logic       LS_i_and,
    input  logic       LS_i_or,
    input  logic       LS_i_not,
    input  logic       LS_i_xor,
    output logic       LS_o_busy,
    output logic       LS_o_done,
    output logic       LS_o_pass,
    output logic [1:0] LS_o_fail_vec,
    output logic [3:0] LS_o_err_mask
);

    localparam int unsigned    CntW    = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_d, pass_q, pass_d;
    logic [1:0]      fail_vec_q, fail_vec_d;
    logic [3:0]      err_mask_q, err_mask_d;
    logic [1:0]      ab_q;
    logic            busy_q, done_q;

    logic [3:0] expected;
    logic [3:0] observed;
    logic [3:0] mism;

    // Bit order matches err_mask: [0]=AND, [1]=OR, [2]=NOT, [3]=XOR.
    always_comb begin
        expected = {vec_q[1] ^ vec_q[0], ~vec_q[1], vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
        observed = {LS_i_xor, LS_i_not, LS_i_or, LS_i_and};
        mism     = expected ^ observed;
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_vec_d = fail_vec_q;
        err_mask_d = err_mask_q;
        case (state_q)
            StIdle: begin
                if (LS_i_start) begin
                    state_d    = StRun;
                    vec_d      = 2'd0;
                    cnt_d      = '0;
                    err_mask_d = 4'd0;
                    fail_vec_d = 2'd0;
                end
            end
            StRun: begin
                if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    err_mask_d = err_mask_q | mism;
                    // Only the first failing vector of the run is recorded.
                    if ((|mism) && (err_mask_q == 4'd0)) begin
                        fail_vec_d = vec_q;
                    end
                    if (((|mism) && STOP_ON_FAIL) || (vec_q == 2'd3)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        pass_d  = ((err_mask_q | mism) == 4'd0);
                    end else begin
                        vec_d = vec_q + 2'd1;
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge LS_i_clk) begin
        if (LS_i_rst) begin
            state_q    <= StIdle;
            vec_q      <= 2'd0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= 2'd0;
            err_mask_q <= 4'd0;
            ab_q       <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_vec_q <= fail_vec_d;
            err_mask_q <= err_mask_d;
            // Outputs follow the next state so they are registered yet cycle-aligned.
            ab_q       <= (state_d == StRun) ? vec_d : 2'd0;
            busy_q     <= (state_d == StRun);
        end
    end

    assign LS_o_a        = ab_q[1];
    assign LS_o_b        = ab_q[0];
    assign LS_o_busy     = busy_q;
    assign LS_o_done     = done_q;
    assign LS_o_pass     = pass_q;
    assign LS_o_fail_vec = fail_vec_q;
    assign LS_o_err_mask = err_mask_q;

endmodule
